// File: rtl/button_round_ctrl_if.sv
// Button round controller bus: buttons, round control, sequence memory read and status.
// The controller side uses the slave modport; the host/memory side uses master.
interface button_round_ctrl_if;
  logic        red_button;
  logic        blue_button;
  logic        green_button;
  logic        yellow_button;
  logic        start;
  logic [5:0]  round_len;
  logic [4:0]  seq_addr;
  logic [1:0]  seq_data;
  logic [31:0] status_out;

  modport master (
    output red_button,
    output blue_button,
    output green_button,
    output yellow_button,
    output start,
    output round_len,
    output seq_data,
    input  seq_addr,
    input  status_out
  );

  modport slave (
    input  red_button,
    input  blue_button,
    input  green_button,
    input  yellow_button,
    input  start,
    input  round_len,
    input  seq_data,
    output seq_addr,
    output status_out
  );
endinterface

// File: rtl/button_round_ctrl.sv
// Player-round checker: conditions four buttons and compares presses to sequence memory.
// Define BUTTON_DEBOUNCE_EN to add per-button DEBOUNCE_CYCLES debouncing.
module button_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int MAX_LEN         = 32
) (
  input logic               clock,
  input logic               reset,
  button_round_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    LEN_MAX = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    CHECK,
    WAIT_RELEASE,
    PASS,
    FAIL
  } state_t;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] cond;
  logic [3:0] prev;
  logic [1:0] fill;
  logic       armed;
  logic       onehot;
  logic       press;
  logic [1:0] col;

  // bit position equals the colour code
  assign raw = {bus.yellow_button, bus.green_button,
                bus.blue_button, bus.red_button};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0][CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cond <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == cond[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == D_LAST) begin
          cond[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign cond = sync2;
`endif

  // a button held through reset must be released before it can press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev  <= '0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      prev <= cond;
      if (fill != 2'd2) begin
        fill <= fill + 2'd1;
      end
      if (fill == 2'd2 && cond == '0 && sync2 == '0) begin
        armed <= 1'b1;
      end
    end
  end

  assign onehot = (cond != '0) &&
                  ((cond & (cond - 4'd1)) == '0);
  assign press  = armed && (prev == '0) && onehot;

  always_comb begin
    col = 2'd0;
    case (cond)
      4'b0010: col = 2'd1;
      4'b0100: col = 2'd2;
      4'b1000: col = 2'd3;
      default: col = 2'd0;
    endcase
  end

  state_t        state_q, state_d;
  logic [4:0]    index_q, index_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    len_q, len_d;
  logic [1:0]    colour_q, colour_d;
  logic          timeout_q, timeout_d;
  logic          bad_len_q, bad_len_d;
  logic          any_q, any_d;
  logic          go;
  logic [31:0]   status_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= '0;
      timer_q   <= '0;
      len_q     <= '0;
      colour_q  <= '0;
      timeout_q <= 1'b0;
      bad_len_q <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      timer_q   <= timer_d;
      len_q     <= len_d;
      colour_q  <= colour_d;
      timeout_q <= timeout_d;
      bad_len_q <= bad_len_d;
      any_q     <= any_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    timer_d   = timer_q;
    len_d     = len_q;
    colour_d  = colour_q;
    timeout_d = timeout_q;
    bad_len_d = bad_len_q;
    any_d     = any_q;
    go = bus.start &&
         (state_q == IDLE || state_q == PASS ||
          state_q == FAIL);
    if (go) begin
      index_d   = '0;
      timer_d   = '0;
      len_d     = bus.round_len;
      timeout_d = 1'b0;
      bad_len_d = 1'b0;
      any_d     = 1'b0;
      if (bus.round_len != '0 &&
          bus.round_len <= LEN_MAX) begin
        state_d = WAIT_PRESS;
      end else begin
        state_d   = FAIL;
        bad_len_d = 1'b1;
      end
    end else begin
      case (state_q)
        WAIT_PRESS: begin
          if (timer_q == T_LAST) begin
            state_d   = FAIL;
            timeout_d = 1'b1;
          end else if (press) begin
            colour_d = col;
            any_d    = 1'b1;
            state_d  = CHECK;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        CHECK: begin
          state_d = (colour_q == bus.seq_data) ?
                    WAIT_RELEASE : FAIL;
        end
        WAIT_RELEASE: begin
          if (cond == '0) begin
            if ({1'b0, index_q} == len_q - 6'd1) begin
              state_d = PASS;
            end else begin
              index_d = index_q + 5'd1;
              timer_d = '0;
              state_d = WAIT_PRESS;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= {19'd0, any_q, colour_q, index_q,
                   bad_len_q, timeout_q,
                   state_q == FAIL, state_q == PASS,
                   state_q == WAIT_PRESS ||
                   state_q == CHECK ||
                   state_q == WAIT_RELEASE};
    end
  end

  assign bus.seq_addr   = index_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_button_round_ctrl.sv
// Self-checking bench for button_round_ctrl: vector table, corner sequences,
// and randomized rounds against a press-by-press reference model.
module tb_button_round_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  button_round_ctrl_if bus ();

  button_round_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .TIMEOUT_CYCLES (100),
    .MAX_LEN        (32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [1:0] mem [32];
  assign bus.seq_data = mem[bus.seq_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int m_col = 0;

  typedef struct {
    logic [5:0]  len;
    logic [63:0] mem;
    logic [63:0] seq;
    int          npress;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(
    input bit busy, input bit pass, input bit fail,
    input bit to, input bit bl, input int idx,
    input int col, input bit any);
    return 32'(busy) + 32'(pass) * 2 + 32'(fail) * 4 +
           32'(to) * 8 + 32'(bl) * 16 + 32'(idx) * 32 +
           32'(col) * 1024 + 32'(any) * 4096;
  endfunction

  task automatic set_btn(input logic [3:0] v);
    bus.red_button    = v[0];
    bus.blue_button   = v[1];
    bus.green_button  = v[2];
    bus.yellow_button = v[3];
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] v,
                       input int hold, input int gap);
    @(negedge clock);
    set_btn(v);
    cyc(hold);
    set_btn(4'b0000);
    cyc(gap);
  endtask

  function automatic logic [3:0] hot(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return v;
  endfunction

  task automatic start_round(input logic [5:0] len);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.round_len = len;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic run_random(input int r);
    logic [5:0] len;
    int n, c, idx, hold, gap;
    bit done, pass, fail, to, bl, any;
    logic [1:0] w;
    if ($urandom_range(0, 7) == 0)
      len = ($urandom_range(0, 1) == 0) ? 6'd0 :
            6'($urandom_range(33, 63));
    else
      len = 6'($urandom_range(1, 6));
    for (int i = 0; i < 32; i++)
      mem[i] = 2'($urandom_range(0, 3));
    start_round(len);
    done = 0; pass = 0; fail = 0; to = 0;
    bl = 0; any = 0; idx = 0;
    if (len == 0 || len > 32) begin
      fail = 1;
      bl   = 1;
    end else begin
      n = ($urandom_range(0, 3) == 0) ?
          $urandom_range(0, int'(len) - 1) : int'(len);
      for (int k = 0; k < n && !done; k++) begin
        w = mem[k];
        c = ($urandom_range(0, 7) == 0) ?
            $urandom_range(0, 3) : int'(w);
        hold = $urandom_range(20, 30);
        gap  = $urandom_range(20, 30);
        press(hot(c), hold, gap);
        any   = 1;
        m_col = c;
        if (c != int'(w)) begin
          fail = 1;
          done = 1;
        end else if (k == int'(len) - 1) begin
          pass = 1;
          done = 1;
        end else begin
          idx = k + 1;
        end
      end
      if (!done) begin
        cyc(130);
        fail = 1;
        to   = 1;
      end
    end
    cyc(10);
    check($sformatf("rand%0d status", r), bus.status_out,
          enc(0, pass, fail, to, bl, idx, m_col, any));
    check($sformatf("rand%0d addr", r),
          32'(bus.seq_addr), 32'(idx));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.round_len = '0;
    set_btn(4'b0000);
    for (int i = 0; i < 32; i++) mem[i] = 2'd0;

    vt[0] = '{6'd3,  64'h38, 64'h38, 3, 32'h0000_1C42};
    vt[1] = '{6'd2,  64'h05, 64'h01, 2, 32'h0000_1024};
    vt[2] = '{6'd1,  64'h03, 64'h03, 1, 32'h0000_1C02};
    vt[3] = '{6'd1,  64'h02, 64'h01, 1, 32'h0000_1404};
    vt[4] = '{6'd4,  64'h39, 64'h39, 4, 32'h0000_1062};
    vt[5] = '{6'd0,  64'h00, 64'h00, 0, 32'h0000_0014};
    vt[6] = '{6'd33, 64'h00, 64'h00, 0, 32'h0000_0014};
    vt[7] = '{6'd2,  64'h0C, 64'h0C, 2, 32'h0000_1C22};
    vt[8] = '{6'd32, 64'hE4E4E4E4E4E4E4E4,
                     64'hE4E4E4E4E4E4E4E4, 32,
                     32'h0000_1FE2};
    vt[9] = '{6'd5,  64'h00, 64'h10, 3, 32'h0000_1444};

    cyc(3);
    check("reset status", bus.status_out, 32'h0);
    check("reset addr", 32'(bus.seq_addr), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    cyc(5);
    check("idle status", bus.status_out, 32'h0);

    for (int v = 0; v < 10; v++) begin
      logic [63:0] mv, sv;
      mv = vt[v].mem;
      sv = vt[v].seq;
      for (int i = 0; i < 32; i++) mem[i] = mv[2*i +: 2];
      start_round(vt[v].len);
      for (int k = 0; k < vt[v].npress; k++)
        press(hot(int'(sv[2*k +: 2])), 20, 20);
      cyc(25);
      check($sformatf("vec%0d status", v),
            bus.status_out, vt[v].exp);
      check($sformatf("vec%0d addr", v),
            32'(bus.seq_addr), 32'(vt[v].exp[9:5]));
    end
    m_col = 1;

    start_round(6'd1);
    cyc(100);
    check("timeout edge-1", bus.status_out, 32'h401);
    cyc(1);
    check("timeout edge", bus.status_out, 32'h40C);

    mem[0] = 2'd0;
    start_round(6'd1);
    press(4'b1001, 20, 20);
    check("multi no press", bus.status_out, 32'h401);
    start_round(6'd0);
    cyc(5);
    check("start ignored", bus.status_out, 32'h401);
    cyc(80);
    check("multi timeout", bus.status_out, 32'h40C);
    start_round(6'd0);
    cyc(5);
    check("bad len", bus.status_out, 32'h414);

    for (int i = 0; i < 32; i++) mem[i] = 2'd0;
    start_round(6'd6);
    for (int k = 0; k < 4; k++) press(4'b0001, 20, 20);
    @(negedge clock);
    set_btn(4'b0001);
    cyc(10);
    check("mid addr", 32'(bus.seq_addr), 32'd4);
    check("mid status", bus.status_out, 32'h1081);
    #2 reset = 1'b1;
    #1;
    check("async status", bus.status_out, 32'h0);
    check("async addr", 32'(bus.seq_addr), 32'h0);
    cyc(3);
    reset = 1'b0;
    cyc(10);
    check("post reset idle", bus.status_out, 32'h0);
    start_round(6'd1);
    cyc(30);
    check("held thru reset", bus.status_out, 32'h1);
    set_btn(4'b0000);
    cyc(20);
    press(4'b0001, 20, 20);
    cyc(5);
    check("after rearm", bus.status_out, 32'h1002);

    mem[0] = 2'd1;
    start_round(6'd1);
`ifdef BUTTON_DEBOUNCE_EN
    press(4'b0010, 5, 30);
    check("glitch dropped", bus.status_out, 32'h1);
    press(4'b0010, 40, 25);
`else
    press(4'b0010, 1, 25);
`endif
    check("blue press", bus.status_out, 32'h1402);
    m_col = 1;

    for (int r = 0; r < 16; r++) run_random(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
